// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage with EX/MEM forwarding and a one-entry skid buffer.
// Forwarding is compiled in only when ALU_OPERAND_STAGE_FWD_EN is defined.
module alu_operand_stage #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned NSRC  = 4,
   localparam int unsigned SELW  = $clog2(NSRC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [SELW-1:0]       sel_a,
   input  logic [SELW-1:0]       sel_b,
   input  logic [4:0]            rs1_idx,
   input  logic [4:0]            rs2_idx,
   input  logic                  fwd_ex_valid,
   input  logic                  fwd_mem_valid,
   input  logic [4:0]            fwd_ex_rd,
   input  logic [4:0]            fwd_mem_rd,
   input  logic [WIDTH-1:0]      fwd_ex_data,
   input  logic [WIDTH-1:0]      fwd_mem_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      op_a,
   output logic [WIDTH-1:0]      op_b,
   output logic [1:0]            hit_a,
   output logic [1:0]            hit_b
);

   typedef struct packed {
      logic [1:0]       hit_a;
      logic [1:0]       hit_b;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } entry_t;

   entry_t out_q, out_d, skid_q, skid_d, in_entry;
   logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic   accept, drain;

   // Out-of-range selects never match a source and yield zero.
   function automatic logic [WIDTH-1:0] select_src(input logic [SELW-1:0] sel);
      logic [WIDTH-1:0] val;
      val = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (sel == SELW'(k)) val = src_data[k*WIDTH +: WIDTH];
      end
      return val;
   endfunction

`ifdef ALU_OPERAND_STAGE_FWD_EN
   function automatic logic [WIDTH+1:0] forward(input logic [SELW-1:0] sel,
                                                input logic [4:0]      idx,
                                                input logic [WIDTH-1:0] base);
      logic [WIDTH-1:0] val;
      logic [1:0]       hit;
      val = base;
      hit = 2'b00;
      if (sel == '0 && idx != 5'd0) begin
         if (fwd_ex_valid && fwd_ex_rd == idx) begin
            val = fwd_ex_data;
            hit = 2'b01;
         end else if (fwd_mem_valid && fwd_mem_rd == idx) begin
            val = fwd_mem_data;
            hit = 2'b10;
         end
      end
      return {hit, val};
   endfunction

   always_comb begin
      {in_entry.hit_a, in_entry.a} = forward(sel_a, rs1_idx, select_src(sel_a));
      {in_entry.hit_b, in_entry.b} = forward(sel_b, rs2_idx, select_src(sel_b));
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{rs1_idx, rs2_idx, fwd_ex_valid, fwd_mem_valid, fwd_ex_rd, fwd_mem_rd,
                         fwd_ex_data, fwd_mem_data};

   always_comb begin
      in_entry.a     = select_src(sel_a);
      in_entry.b     = select_src(sel_b);
      in_entry.hit_a = 2'b00;
      in_entry.hit_b = 2'b00;
   end
`endif

   assign accept = in_valid && !skid_valid_q;
   assign drain  = out_valid_q && out_ready;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || drain) begin
         // Skid entry is older than anything upstream, so it always goes first.
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = in_entry;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign in_ready  = !skid_valid_q;
   assign out_valid = out_valid_q;
   assign op_a      = out_q.a;
   assign op_b      = out_q.b;
   assign hit_a     = out_q.hit_a;
   assign hit_b     = out_q.hit_b;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage (NSRC = 3) against a queue-based reference model.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_STAGE_FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] src [3];
   logic [95:0] src_data;
   logic [1:0]  sel_a = '0, sel_b = '0;
   logic [4:0]  rs1_idx = '0, rs2_idx = '0;
   logic        fwd_ex_valid = 1'b0, fwd_mem_valid = 1'b0;
   logic [4:0]  fwd_ex_rd = '0, fwd_mem_rd = '0;
   logic [31:0] fwd_ex_data = '0, fwd_mem_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] op_a, op_b;
   logic [1:0]  hit_a, hit_b;

   assign src_data = {src[2], src[1], src[0]};

   alu_operand_stage #(.WIDTH(32), .NSRC(3)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .src_data(src_data), .sel_a(sel_a), .sel_b(sel_b), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
      .fwd_ex_valid(fwd_ex_valid), .fwd_mem_valid(fwd_mem_valid), .fwd_ex_rd(fwd_ex_rd),
      .fwd_mem_rd(fwd_mem_rd), .fwd_ex_data(fwd_ex_data), .fwd_mem_data(fwd_mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
      .hit_a(hit_a), .hit_b(hit_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Reference: the stage is a FIFO of at most two pairs; the head is what the output shows.
   typedef struct {
      logic [31:0] a, b;
      logic [1:0]  ha, hb;
   } item_t;

   item_t q[$];
   bit    last_taken = 1'b0;

   function automatic logic [33:0] ref_operand(input logic [1:0] sel, input logic [4:0] idx);
      logic [31:0] v;
      logic [1:0]  h;
      v = 32'h0;
      if (sel == 2'd0) v = src[0];
      if (sel == 2'd1) v = src[1];
      if (sel == 2'd2) v = src[2];
      h = 2'b00;
      if (FWD_ON && sel == 2'd0 && idx != 5'd0) begin
         if (fwd_ex_valid && fwd_ex_rd == idx) begin
            v = fwd_ex_data;
            h = 2'b01;
         end else if (fwd_mem_valid && fwd_mem_rd == idx) begin
            v = fwd_mem_data;
            h = 2'b10;
         end
      end
      return {h, v};
   endfunction

   always @(posedge clk or posedge rst) begin : model
      int    sz;
      item_t it;
      if (rst) begin
         q.delete();
         last_taken = 1'b0;
      end else begin
         sz = q.size();
         last_taken = 1'b0;
         if (flush) q.delete();
         else begin
            if (sz > 0 && out_ready) void'(q.pop_front());
            if (in_valid && sz < 2) begin
               {it.ha, it.a} = ref_operand(sel_a, rs1_idx);
               {it.hb, it.b} = ref_operand(sel_b, rs2_idx);
               q.push_back(it);
               last_taken = 1'b1;
            end
         end
      end
   end

   task automatic check_outputs();
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         check("op_a", 64'(op_a), 64'(q[0].a));
         check("op_b", 64'(op_b), 64'(q[0].b));
         check("hit_a", 64'(hit_a), 64'(q[0].ha));
         check("hit_b", 64'(hit_b), 64'(q[0].hb));
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic fill_both(input logic [31:0] base);
      out_ready = 1'b0;
      sel_a = 2'd1; sel_b = 2'd2;
      in_valid = 1'b1; src[1] = base;     src[2] = base + 32'h100; step();
      in_valid = 1'b1; src[1] = base + 1; src[2] = base + 32'h101; step();
      in_valid = 1'b0;
      check("fill_in_ready", 64'(in_ready), 64'd0);
   endtask

   logic [31:0] delivered[$];

   initial begin
      src[0] = '0; src[1] = '0; src[2] = '0;

      // Asynchronous reset before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_op_a", 64'(op_a), 64'd0);
      check("rst_op_b", 64'(op_b), 64'd0);
      check("rst_hits", 64'({hit_a, hit_b}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Basic select including out-of-range select.
      src[0] = 32'h10; src[1] = 32'h20; src[2] = 32'h30;
      sel_a = 2'd2; sel_b = 2'd3; out_ready = 1'b1; in_valid = 1'b1;
      step();
      check("sel_op_a", 64'(op_a), 64'h30);
      check("sel_op_b", 64'(op_b), 64'h0);

      // Forwarding priority.
      src[0] = 32'h11; sel_a = 2'd0; sel_b = 2'd0; rs1_idx = 5'd5; rs2_idx = 5'd7;
      fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd5; fwd_ex_data = 32'hAAAA;
      fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'hBBBB;
      step();
      check("fwd_ex_op_a", 64'(op_a), FWD_ON ? 64'hAAAA : 64'h11);
      check("fwd_ex_hit_a", 64'(hit_a), FWD_ON ? 64'd1 : 64'd0);
      check("fwd_none_op_b", 64'(op_b), 64'h11);
      rs1_idx = 5'd0;
      step();
      check("fwd_x0_op_a", 64'(op_a), 64'h11);
      check("fwd_x0_hit_a", 64'(hit_a), 64'd0);
      rs1_idx = 5'd5; fwd_ex_rd = 5'd6;
      step();
      check("fwd_mem_op_a", 64'(op_a), FWD_ON ? 64'hBBBB : 64'h11);
      check("fwd_mem_hit_a", 64'(hit_a), FWD_ON ? 64'd2 : 64'd0);
      in_valid = 1'b0; fwd_ex_valid = 1'b0; fwd_mem_valid = 1'b0;
      step();

      // Backpressure: pairs 1,2,3 with out_ready low for three cycles.
      out_ready = 1'b0; sel_a = 2'd1; sel_b = 2'd2;
      in_valid = 1'b1; src[1] = 32'd1; src[2] = 32'd101; step();
      check("bp_ready_after1", 64'(in_ready), 64'd1);
      src[1] = 32'd2; src[2] = 32'd102; step();
      check("bp_ready_after2", 64'(in_ready), 64'd0);
      src[1] = 32'd3; src[2] = 32'd103; step();
      check("bp_held_op_a", 64'(op_a), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (out_valid && out_ready) delivered.push_back(op_a);
         step();
         if (last_taken && in_valid) in_valid = 1'b0;
      end
      check("bp_count", 64'(delivered.size()), 64'd3);
      for (int i = 0; i < 3 && i < delivered.size(); i++)
         check("bp_order", 64'(delivered[i]), 64'(i + 1));

      // Flush with both entries full and a concurrent input.
      fill_both(32'h50);
      flush = 1'b1; in_valid = 1'b1; src[1] = 32'h99;
      step();
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("flush_no_ghost", 64'(out_valid), 64'd0);
      end

      // Reset with the skid entry full.
      fill_both(32'h70);
      #2 rst = 1'b1;
      #1;
      check("rst_full_out_valid", 64'(out_valid), 64'd0);
      check("rst_full_in_ready", 64'(in_ready), 64'd1);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_no_ghost", 64'(out_valid), 64'd0);
      end

      // Randomized traffic; upstream holds a request until it is taken.
      for (int i = 0; i < 400; i++) begin
         flush     = ($urandom_range(0, 19) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if (!(in_valid && !last_taken)) begin
            in_valid      = $urandom_range(0, 2) != 0;
            src[0]        = $urandom; src[1] = $urandom; src[2] = $urandom;
            sel_a         = 2'($urandom_range(0, 3));
            sel_b         = 2'($urandom_range(0, 3));
            rs1_idx       = 5'($urandom_range(0, 3));
            rs2_idx       = 5'($urandom_range(0, 3));
            fwd_ex_valid  = $urandom_range(0, 1) != 0;
            fwd_mem_valid = $urandom_range(0, 1) != 0;
            fwd_ex_rd     = 5'($urandom_range(0, 3));
            fwd_mem_rd    = 5'($urandom_range(0, 3));
            fwd_ex_data   = $urandom;
            fwd_mem_data  = $urandom;
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
